display_digit_scanner: RTL and testbench

Time-multiplexed scanner for the 4-digit common-anode seven-segment display. It steps through four packed BCD digits (HH:MM) and presents one digit at a time on `o_BCD_Num` to the registered BCD-to-7-segment decoder that sits directly downstream. It drives the active-low digit anodes, delayed so they line up with the decoder's one-cycle output latency. It also applies leading-zero blanking, blink masking for alarm/time-set mode, and blanking of invalid codes, because the downstream decoder renders out-of-range codes as "0".

---
 rtl/display_digit_scanner.sv | 131 +++++++++++++
 tb/tb_display_digit_scanner.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_digit_scanner.sv
// ---------------------------------------------------------------------------
// display_digit_scanner
//
// Time-multiplexed scanner for a 4-digit common-anode seven-segment display
// showing HH:MM as four packed BCD digits. One digit at a time is presented
// on o_BCD_Num to a registered BCD-to-7-segment decoder that sits directly
// downstream. The active-low anodes are delayed by one extra register so
// that they change on the same edge as the decoder's segment outputs.
//
// A digit is hidden (its anode kept high) when:
//   - its code is not a valid BCD value (the decoder would show "0"),
//   - it is the hours-tens digit, it is 0, and leading-zero blanking is on,
//   - the blink phase is 1 and its bit in i_Blink_Mask is set.
//
// Parameters
//   CLKS_PER_DIGIT : clocks each digit stays selected (>= 2)
//   BLINK_CLKS     : clocks per blink half-period (>= 2)
//
// Ports
//   i_Clk                : system clock, rising edge
//   i_Reset              : synchronous active-high reset
//   i_Digits[15:0]       : {hours tens, hours units, min tens, min units}
//   i_Blank_Leading_Zero : blank hours-tens digit when it is 0
//   i_Blink_Mask[3:0]    : bit n set -> digit n blinks
//   o_BCD_Num[3:0]       : registered digit code to the decoder
//   o_Anodes[3:0]        : registered active-low digit enables
//   o_Blink_Phase        : 1 = masked digits currently hidden
// ---------------------------------------------------------------------------
module display_digit_scanner #(
    parameter int CLKS_PER_DIGIT = 100000,
    parameter int BLINK_CLKS     = 50000000
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [15:0] i_Digits,
    input  logic        i_Blank_Leading_Zero,
    input  logic [3:0]  i_Blink_Mask,
    output logic [3:0]  o_BCD_Num,
    output logic [3:0]  o_Anodes,
    output logic        o_Blink_Phase
);

    localparam int SCAN_W  = $clog2(CLKS_PER_DIGIT);
    localparam int BLINK_W = $clog2(BLINK_CLKS);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(CLKS_PER_DIGIT - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CLKS - 1);

    // Scan prescaler and digit index
    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [1:0]         index_q,     index_d;
    // Blink counter and phase
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q,     phase_d;
    // Stage 1: code, visibility, delayed index
    logic [3:0]         bcd_q,       bcd_d;
    logic               show_q,      show_d;
    logic [1:0]         index_dly_q, index_dly_d;
    // Stage 2: anodes
    logic [3:0]         anodes_q,    anodes_d;

    // Unpacked view of the four digits, indexed by scan position
    logic [3:0] digit_arr [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign digit_arr[gi] = i_Digits[4*gi +: 4];
        end
    endgenerate

    logic [3:0] sel_code;
    logic       scan_wrap;
    logic       blink_wrap;

    always_comb begin
        sel_code   = digit_arr[index_q];
        scan_wrap  = (scan_cnt_q == SCAN_LAST);
        blink_wrap = (blink_cnt_q == BLINK_LAST);

        // Scan prescaler; the index advances only on the wrap cycle
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        index_d    = scan_wrap ? index_q + 2'd1 : index_q;

        // Blink counter; the phase toggles on the wrap cycle
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
        phase_d     = blink_wrap ? ~phase_q : phase_q;

        // Stage 1. Visibility uses the current (pre-toggle) blink phase.
        bcd_d       = sel_code;
        index_dly_d = index_q;
        show_d      = 1'b1;
        if (sel_code > 4'd9)
            show_d = 1'b0;
        if ((index_q == 2'd3) && i_Blank_Leading_Zero && (sel_code == 4'd0))
            show_d = 1'b0;
        if (phase_q && i_Blink_Mask[index_q])
            show_d = 1'b0;

        // Stage 2: at most one anode low, and only for a visible digit
        anodes_d = 4'b1111;
        if (show_q)
            anodes_d[index_dly_q] = 1'b0;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            scan_cnt_q  <= '0;
            index_q     <= 2'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            bcd_q       <= 4'h0;
            show_q      <= 1'b0;
            index_dly_q <= 2'd0;
            anodes_q    <= 4'b1111;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            index_q     <= index_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            bcd_q       <= bcd_d;
            show_q      <= show_d;
            index_dly_q <= index_dly_d;
            anodes_q    <= anodes_d;
        end
    end

    assign o_BCD_Num     = bcd_q;
    assign o_Anodes      = anodes_q;
    assign o_Blink_Phase = phase_q;

endmodule

// File: tb/tb_display_digit_scanner.sv
// ---------------------------------------------------------------------------
// Testbench for display_digit_scanner (CLKS_PER_DIGIT=4, BLINK_CLKS=8).
// Expected outputs come from a cycle-count model: after n clock edges since
// reset release, the digit selected during edge n is ((n-1)/C)%4, the blink
// phase during edge n is ((n-1)/B)%2, and the anodes show the previous
// edge's digit one cycle later.
// ---------------------------------------------------------------------------
module tb_display_digit_scanner;

    localparam int C = 4;
    localparam int B = 8;

    logic        clk;
    logic        rst;
    logic [15:0] digits;
    logic        blz;
    logic [3:0]  mask;
    logic [3:0]  bcd;
    logic [3:0]  anodes;
    logic        phase;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         n_edges;
    logic [3:0] exp_bcd;
    logic [3:0] exp_an;
    logic       exp_ph;
    logic       prev_show;
    int         prev_idx;

    display_digit_scanner #(
        .CLKS_PER_DIGIT (C),
        .BLINK_CLKS     (B)
    ) dut (
        .i_Clk                (clk),
        .i_Reset              (rst),
        .i_Digits             (digits),
        .i_Blank_Leading_Zero (blz),
        .i_Blink_Mask         (mask),
        .o_BCD_Num            (bcd),
        .o_Anodes             (anodes),
        .o_Blink_Phase        (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic visible(input logic [3:0] code, input int idx,
                                     input logic bl, input logic [3:0] m,
                                     input logic ph);
        if (code > 4'd9) return 1'b0;
        if (idx == 3 && bl && code == 4'd0) return 1'b0;
        if (ph && m[idx]) return 1'b0;
        return 1'b1;
    endfunction

    // Advance one clock edge and update the model; returns #1 after the edge.
    task automatic advance();
        int         idx;
        logic       ph_before;
        logic [3:0] code;
        logic [15:0] sh;
        @(posedge clk);
        if (rst) begin
            n_edges   = 0;
            exp_bcd   = 4'h0;
            exp_an    = 4'b1111;
            exp_ph    = 1'b0;
            prev_show = 1'b0;
            prev_idx  = 0;
        end else begin
            n_edges   = n_edges + 1;
            idx       = ((n_edges - 1) / C) % 4;
            ph_before = (((n_edges - 1) / B) % 2) == 1;
            sh        = digits >> (4 * idx);
            code      = sh[3:0];
            exp_an    = 4'b1111;
            if (prev_show) exp_an[prev_idx] = 1'b0;
            exp_bcd   = code;
            prev_show = visible(code, idx, blz, mask, ph_before);
            prev_idx  = idx;
            exp_ph    = ((n_edges / B) % 2) == 1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        digits = 16'h1234; blz = 1'b0; mask = 4'b0000;
        do_reset();
        for (int i = 0; i < 7; i++) advance();   // mid-scan
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
            checks++;
            if (anodes !== 4'b1111 || bcd !== 4'h0 || phase !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: anodes=%b bcd=%h phase=%b, need 1111 0 0",
                         anodes, bcd, phase);
            end
        end
        rst = 1'b0;
        advance();
        checks++;
        if (bcd !== 4'h4 || anodes !== 4'b1111) begin
            errors++;
            $display("FAIL reset_edge1: bcd=%h anodes=%b, need 4 1111", bcd, anodes);
        end
        advance();
        checks++;
        if (anodes !== 4'b1110) begin
            errors++;
            $display("FAIL reset_edge2: anodes=%b, need 1110", anodes);
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_scan_order();
        int cnt [4];
        digits = 16'h1234; blz = 1'b0; mask = 4'b0000;
        do_reset();
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        for (int i = 0; i < 33; i++) begin
            advance();
            checks++;
            if (bcd !== exp_bcd || anodes !== exp_an) begin
                errors++;
                $display("FAIL scan_cycle%0d: bcd=%h anodes=%b, need %h %b",
                         n_edges, bcd, anodes, exp_bcd, exp_an);
            end
            // one frame of anodes: edges 2..17
            if (n_edges >= 2 && n_edges <= 17)
                for (int k = 0; k < 4; k++)
                    if (anodes == ~(4'b0001 << k)) cnt[k]++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cnt[k] != C) begin
                errors++;
                $display("FAIL scan_dwell%0d: low cycles=%0d, need %0d", k, cnt[k], C);
            end
        end
        $display("test_scan_order done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_leading_zero();
        int low3;
        digits = 16'h0945; mask = 4'b0000;
        for (int pass = 0; pass < 2; pass++) begin
            blz = (pass == 0);
            do_reset();
            low3 = 0;
            for (int i = 0; i < 33; i++) begin
                advance();
                checks++;
                if (bcd !== exp_bcd || anodes !== exp_an) begin
                    errors++;
                    $display("FAIL lz%0d_cycle%0d: bcd=%h anodes=%b, need %h %b",
                             pass, n_edges, bcd, anodes, exp_bcd, exp_an);
                end
                if (anodes == 4'b0111) low3++;
            end
            checks++;
            if (low3 != (blz ? 0 : 2 * C)) begin
                errors++;
                $display("FAIL lz%0d_anode3: low cycles=%0d, need %0d",
                         pass, low3, blz ? 0 : 2 * C);
            end
        end
        $display("test_leading_zero done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_blink();
        int   bad, toggles;
        logic last_ph;
        digits = 16'h1234; blz = 1'b0; mask = 4'b1100;
        do_reset();
        bad = 0; toggles = 0; last_ph = phase;
        for (int i = 0; i < 40; i++) begin
            advance();
            checks++;
            if (bcd !== exp_bcd || anodes !== exp_an || phase !== exp_ph) begin
                errors++;
                $display("FAIL blink_cycle%0d: bcd=%h anodes=%b phase=%b, need %h %b %b",
                         n_edges, bcd, anodes, phase, exp_bcd, exp_an, exp_ph);
            end
            if (phase != last_ph) toggles++;
            last_ph = phase;
            if (anodes[3] == 1'b0 && anodes[2] == 1'b0) bad++;
        end
        checks++;
        if (toggles != 40 / B) begin
            errors++;
            $display("FAIL blink_toggles: toggles=%0d, need %0d", toggles, 40 / B);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL blink_onehot: two anodes low %0d times, need 0", bad);
        end
        $display("test_blink done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_invalid();
        int low1, low0;
        digits = 16'h12A4; blz = 1'b0; mask = 4'b0000;
        do_reset();
        low1 = 0; low0 = 0;
        for (int i = 0; i < 17; i++) begin
            advance();
            if (anodes == 4'b1101) low1++;
            if (anodes == 4'b1110) low0++;
        end
        checks++;
        if (low1 != 0 || low0 != C) begin
            errors++;
            $display("FAIL invalid_code: digit1 low=%0d digit0 low=%0d, need 0 %0d",
                     low1, low0, C);
        end
        $display("test_invalid done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_live_update();
        digits = 16'h1235; blz = 1'b0; mask = 4'b0000;
        do_reset();
        advance();
        advance();
        digits = 16'h1237;
        advance();
        checks++;
        if (bcd !== 4'h7 || anodes !== 4'b1110) begin
            errors++;
            $display("FAIL live_update: bcd=%h anodes=%b, need 7 1110", bcd, anodes);
        end
        advance();
        checks++;
        if (anodes !== 4'b1110) begin
            errors++;
            $display("FAIL live_hold: anodes=%b, need 1110", anodes);
        end
        $display("test_live_update done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 6) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 9) == 0) mask   = 4'($urandom);
            if ($urandom_range(0, 9) == 0) blz    = 1'($urandom);
            rst = ($urandom_range(0, 79) == 0);
            advance();
            checks++;
            if (bcd !== exp_bcd || anodes !== exp_an || phase !== exp_ph) begin
                errors++;
                $display("FAIL random_cycle%0d: bcd=%h anodes=%b phase=%b, need %h %b %b",
                         i, bcd, anodes, phase, exp_bcd, exp_an, exp_ph);
            end
        end
        rst = 1'b0;
        $display("test_random done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        rst = 1'b1; digits = 16'h0; blz = 1'b0; mask = 4'b0;
        n_edges = 0; exp_bcd = 4'h0; exp_an = 4'hF; exp_ph = 1'b0;
        prev_show = 1'b0; prev_idx = 0;
        test_reset();
        test_scan_order();
        test_leading_zero();
        test_blink();
        test_invalid();
        test_live_update();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
